// File: rtl/lzw_pkg.sv
// Shared constants and the controller state type for the LZW dictionary.
package lzw_pkg;

  localparam int CODE_W = 13;
  localparam int CHAR_W = 8;
  localparam int SLOT_W = 12;
  localparam int CNT_W  = 12;

  localparam logic [CODE_W-1:0] EMPTY_MARK = 13'h1FFF;
  localparam logic [SLOT_W-1:0] HASH_MIN   = 12'd256;
  localparam logic [SLOT_W-1:0] SLOT_MAX   = 12'd4095;
  // Number of hashed slots; also the most probes one lookup can make.
  localparam logic [SLOT_W-1:0] PROBE_MAX  = 12'd3840;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    CMP,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/dict_ctrl_if.sv
// Lookup request / result handshake between a client and the dictionary.
interface dict_ctrl_if;
  import lzw_pkg::*;

  logic              lkp_valid;
  logic              lkp_ready;
  logic [CODE_W-1:0] lkp_prefix;
  logic [CHAR_W-1:0] lkp_char;
  logic              lkp_ins;
  logic              res_valid;
  logic              res_hit;
  logic [CODE_W-1:0] res_code;

  modport master (
    output lkp_valid, lkp_prefix, lkp_char, lkp_ins,
    input  lkp_ready, res_valid, res_hit, res_code
  );

  modport slave (
    input  lkp_valid, lkp_prefix, lkp_char, lkp_ins,
    output lkp_ready, res_valid, res_hit, res_code
  );

endinterface

// File: rtl/dict_hash.sv
// Probe-slot arithmetic: initial hash of a (prefix, char) pair and the
// linear-probe successor, which skips the literal codes 0..255.
module dict_hash
  import lzw_pkg::*;
(
  input  logic [SLOT_W-1:0] prefix_lo,
  input  logic [CHAR_W-1:0] char_in,
  input  logic [SLOT_W-1:0] slot,
  output logic [SLOT_W-1:0] init_slot,
  output logic [SLOT_W-1:0] next_slot
);

  logic [SLOT_W-1:0] raw;

  // Fold the char into the prefix; lift hashes that land on literals.
  always_comb begin
    raw       = {char_in, 4'h0} ^ prefix_lo;
    init_slot = (raw < HASH_MIN) ? (raw | HASH_MIN) : raw;
    next_slot = (slot == SLOT_MAX) ? HASH_MIN : slot + 12'd1;
  end

endmodule

// File: rtl/dict_ctrl.sv
// LZW dictionary controller: clears the hashed table, then serves lookups
// with linear probing and optional insertion of missing pairs.
module dict_ctrl #(
  parameter int unsigned                  MAX_ENTRIES = 3584,
  parameter logic [lzw_pkg::CODE_W-1:0]   EMPTY_MARK  = lzw_pkg::EMPTY_MARK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_req,
  dict_ctrl_if.slave                    lkp,
  output logic                          dict_full,
  output logic                          clr_busy,
  output logic [lzw_pkg::CNT_W-1:0]     entry_cnt,
  output logic [lzw_pkg::CODE_W-1:0]    addr,
  output logic                          wea_pcram,
  output logic                          wea_acram,
  output logic [lzw_pkg::CODE_W-1:0]    string_data,
  output logic [lzw_pkg::CHAR_W-1:0]    char_data,
  input  logic [lzw_pkg::CODE_W-1:0]    prefix_data,
  input  logic [lzw_pkg::CHAR_W-1:0]    append_data
);
  import lzw_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ENTRIES);

  state_t            state, state_next;
  logic [SLOT_W-1:0] slot, slot_d;
  logic [SLOT_W-1:0] probe, probe_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              res_hit_q, res_hit_d;
  logic [CODE_W-1:0] res_code_q, res_code_d;
  logic              load_lkp;
  logic [CODE_W-1:0] lat_prefix;
  logic [CHAR_W-1:0] lat_char;
  logic              lat_ins;
  logic [SLOT_W-1:0] init_slot, next_slot;

  dict_hash u_hash (
    .prefix_lo (lkp.lkp_prefix[SLOT_W-1:0]),
    .char_in   (lkp.lkp_char),
    .slot      (slot),
    .init_slot (init_slot),
    .next_slot (next_slot)
  );

  assign dict_full    = (entry_cnt == MAX_CNT);
  assign lkp.res_hit  = res_hit_q;
  assign lkp.res_code = res_code_q;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next state, datapath next values and RAM/handshake outputs.
  always_comb begin
    state_next      = state;
    slot_d          = slot;
    probe_d         = probe;
    cnt_d           = entry_cnt;
    res_hit_d       = res_hit_q;
    res_code_d      = res_code_q;
    load_lkp        = 1'b0;
    lkp.lkp_ready   = 1'b0;
    lkp.res_valid   = 1'b0;
    clr_busy        = 1'b0;
    wea_pcram       = 1'b0;
    wea_acram       = 1'b0;
    string_data     = '0;
    char_data       = '0;
    addr            = {1'b0, slot};
    case (state)
      CLEAR: begin
        // Outputs stay quiet while reset is held, even though the sweep is armed.
        clr_busy    = 1'b1;
        wea_pcram   = ~rst;
        string_data = rst ? '0 : EMPTY_MARK;
        cnt_d       = '0;
        slot_d      = next_slot;
        if (slot == SLOT_MAX) state_next = IDLE;
      end
      IDLE: begin
        lkp.lkp_ready = ~clr_req;
        if (clr_req) begin
          state_next = CLEAR;
          slot_d     = HASH_MIN;
        end else if (lkp.lkp_valid) begin
          state_next = READ;
          load_lkp   = 1'b1;
          slot_d     = init_slot;
          probe_d    = 12'd1;
        end
      end
      READ: begin
        state_next = CMP;
      end
      CMP: begin
        if (prefix_data == EMPTY_MARK) begin
          if (lat_ins && !dict_full) begin
            state_next = WRITE;
          end else begin
            res_hit_d  = 1'b0;
            res_code_d = EMPTY_MARK;
            state_next = RESP;
          end
        end else if (prefix_data == lat_prefix && append_data == lat_char) begin
          res_hit_d  = 1'b1;
          res_code_d = {1'b0, slot};
          state_next = RESP;
        end else if (probe == PROBE_MAX) begin
          res_hit_d  = 1'b0;
          res_code_d = EMPTY_MARK;
          state_next = RESP;
        end else begin
          slot_d     = next_slot;
          probe_d    = probe + 12'd1;
          state_next = READ;
        end
      end
      WRITE: begin
        wea_pcram   = 1'b1;
        wea_acram   = 1'b1;
        string_data = lat_prefix;
        char_data   = lat_char;
        cnt_d       = entry_cnt + 12'd1;
        res_hit_d   = 1'b0;
        res_code_d  = {1'b0, slot};
        state_next  = RESP;
      end
      RESP: begin
        lkp.res_valid = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Datapath registers: probe slot, probe count, entry count, result, request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= HASH_MIN;
      probe      <= '0;
      entry_cnt  <= '0;
      res_hit_q  <= 1'b0;
      res_code_q <= '0;
      lat_prefix <= '0;
      lat_char   <= '0;
      lat_ins    <= 1'b0;
    end else begin
      slot       <= slot_d;
      probe      <= probe_d;
      entry_cnt  <= cnt_d;
      res_hit_q  <= res_hit_d;
      res_code_q <= res_code_d;
      if (load_lkp) begin
        lat_prefix <= lkp.lkp_prefix;
        lat_char   <= lkp.lkp_char;
        lat_ins    <= lkp.lkp_ins;
      end
    end
  end

endmodule

// File: tb/tb_dict_ctrl.sv
// Self-checking bench for dict_ctrl: directed vector table, clear/reset
// corner sequences and randomized lookups against a table-level model.
module tb_dict_ctrl;

  localparam int          TB_MAX = 32;
  localparam logic [12:0] EMPTY  = 13'h1FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        dict_full, clr_busy, wea_pcram, wea_acram;
  logic [11:0] entry_cnt;
  logic [12:0] addr, string_data, prefix_data;
  logic [7:0]  char_data, append_data;

  dict_ctrl_if lkp_if ();

  dict_ctrl #(.MAX_ENTRIES(TB_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_req     (clr_req),
    .lkp         (lkp_if),
    .dict_full   (dict_full),
    .clr_busy    (clr_busy),
    .entry_cnt   (entry_cnt),
    .addr        (addr),
    .wea_pcram   (wea_pcram),
    .wea_acram   (wea_acram),
    .string_data (string_data),
    .char_data   (char_data),
    .prefix_data (prefix_data),
    .append_data (append_data)
  );

  always #5 clk = ~clk;

  // Dictionary RAMs with one-cycle registered read.
  logic [12:0] prefix_mem [4096];
  logic [7:0]  append_mem [4096];

  always @(posedge clk) begin
    if (wea_pcram) prefix_mem[addr[11:0]] <= string_data;
    if (wea_acram) append_mem[addr[11:0]] <= char_data;
    prefix_data <= prefix_mem[addr[11:0]];
    append_data <= append_mem[addr[11:0]];
  end

  // Write strobe monitor.
  int          pc_writes = 0;
  int          ac_writes = 0;
  logic [12:0] wr_addr = '0;
  logic [12:0] wr_pref = '0;
  logic [7:0]  wr_char = '0;

  always @(negedge clk) begin
    if (wea_pcram) begin
      pc_writes++;
      wr_addr = addr;
      wr_pref = string_data;
    end
    if (wea_acram) begin
      ac_writes++;
      wr_char = char_data;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy and stored pair per hashed slot.
  bit          m_used [4096];
  logic [12:0] m_pref [4096];
  logic [7:0]  m_char [4096];
  int          m_cnt;

  task automatic modelReset();
    for (int i = 0; i < 4096; i++) m_used[i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic modelLookup(input logic [12:0] p, input logic [7:0] c, input bit ins,
                             output bit hit, output logic [12:0] code, output int lat,
                             output bit wrote);
    int h;
    h = (int'(c) * 16) ^ (int'(p) % 4096);
    if (h < 256) h = h + 256;
    hit = 1'b0; code = EMPTY; wrote = 1'b0; lat = 3 + 2 * 3839;
    for (int n = 0; n < 3840; n++) begin
      if (!m_used[h]) begin
        if (ins && m_cnt < TB_MAX) begin
          m_used[h] = 1'b1; m_pref[h] = p; m_char[h] = c; m_cnt++;
          code = 13'(h); wrote = 1'b1; lat = 4 + 2 * n;
        end else begin
          lat = 3 + 2 * n;
        end
        return;
      end
      if (m_pref[h] == p && m_char[h] == c) begin
        hit = 1'b1; code = 13'(h); lat = 3 + 2 * n;
        return;
      end
      h = (h == 4095) ? 256 : h + 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Drives one lookup and measures result, latency and write strobes.
  task automatic applyStimulus(input logic [12:0] p, input logic [7:0] c, input bit ins,
                               output bit hit, output logic [12:0] code, output int lat,
                               output int pcw, output int acw,
                               output bit valid_after, output logic [12:0] code_after);
    int k;
    int pc0, ac0;
    k = 0;
    while (!lkp_if.lkp_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    pc0 = pc_writes;
    ac0 = ac_writes;
    lkp_if.lkp_valid  = 1'b1;
    lkp_if.lkp_prefix = p;
    lkp_if.lkp_char   = c;
    lkp_if.lkp_ins    = ins;
    @(posedge clk);
    lat = 0;
    while (lat < 9000) begin
      @(negedge clk);
      lkp_if.lkp_valid = 1'b0;
      lat++;
      if (lkp_if.res_valid) break;
    end
    if (!lkp_if.res_valid) lat = -1;
    hit  = lkp_if.res_hit;
    code = lkp_if.res_code;
    @(negedge clk);
    valid_after = lkp_if.res_valid;
    code_after  = lkp_if.res_code;
    pcw = pc_writes - pc0;
    acw = ac_writes - ac0;
  endtask

  task automatic runLookup(input string name, input logic [12:0] p, input logic [7:0] c,
                           input bit ins, input bit eh, input logic [12:0] ec,
                           input int el, input bit ew);
    bit          hit, va;
    logic [12:0] code, ca;
    int          lat, pcw, acw;
    applyStimulus(p, c, ins, hit, code, lat, pcw, acw, va, ca);
    checkOutput({name, " hit"}, 32'(hit), 32'(eh));
    checkOutput({name, " code"}, 32'(code), 32'(ec));
    checkOutput({name, " latency"}, 32'(lat), 32'(el));
    checkOutput({name, " prefix writes"}, 32'(pcw), ew ? 32'd1 : 32'd0);
    checkOutput({name, " append writes"}, 32'(acw), ew ? 32'd1 : 32'd0);
    checkOutput({name, " strobe width"}, 32'(va), 32'd0);
    checkOutput({name, " code hold"}, 32'(ca), 32'(ec));
    if (ew) begin
      checkOutput({name, " write slot"}, 32'(wr_addr), 32'(ec));
      checkOutput({name, " write data"}, {11'd0, wr_pref, wr_char}, {11'd0, p, c});
    end
  endtask

  // Follows a clear sweep from its first slot until the controller goes idle.
  task automatic sweepCheck(input string name);
    int n, bad, rv;
    n = 0; bad = 0; rv = 0;
    #1;
    while (clr_busy && n < 5000) begin
      if (addr != 13'(256 + n) || !wea_pcram || wea_acram || string_data != EMPTY) bad++;
      if (lkp_if.res_valid || lkp_if.lkp_ready) rv++;
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput({name, " length"}, 32'(n), 32'd3840);
    checkOutput({name, " slot sequence"}, 32'(bad), 32'd0);
    checkOutput({name, " handshake quiet"}, 32'(rv), 32'd0);
    checkOutput({name, " ready after"}, 32'(lkp_if.lkp_ready), 32'd1);
    checkOutput({name, " entry_cnt"}, 32'(entry_cnt), 32'd0);
  endtask

  typedef struct {
    logic [12:0] prefix;
    logic [7:0]  ch;
    bit          ins;
    bit          hit;
    logic [12:0] code;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit          eh, ew;
    logic [12:0] ec, rp;
    logic [7:0]  rc;
    bit          ri;
    int          el, dirty;

    vecs[0] = '{13'h041, 8'h42, 1'b1, 1'b0, 13'h461, 4};
    vecs[1] = '{13'h041, 8'h42, 1'b1, 1'b1, 13'h461, 3};
    vecs[2] = '{13'h041, 8'h42, 1'b0, 1'b1, 13'h461, 3};
    vecs[3] = '{13'h041, 8'h43, 1'b0, 1'b0, 13'h1FFF, 3};
    vecs[4] = '{13'h005, 8'h00, 1'b1, 1'b0, 13'h105, 4};
    vecs[5] = '{13'h00F, 8'hFF, 1'b1, 1'b0, 13'hFFF, 4};
    vecs[6] = '{13'h01F, 8'hFE, 1'b1, 1'b0, 13'h100, 6};
    vecs[7] = '{13'h01F, 8'hFE, 1'b0, 1'b1, 13'h100, 5};
    vecs[8] = '{13'h001, 8'h46, 1'b0, 1'b0, 13'h1FFF, 5};
    vecs[9] = '{13'h001, 8'h46, 1'b1, 1'b0, 13'h462, 6};

    rst = 1'b1;
    clr_req = 1'b0;
    lkp_if.lkp_valid = 1'b0;
    lkp_if.lkp_prefix = '0;
    lkp_if.lkp_char = '0;
    lkp_if.lkp_ins = 1'b0;
    modelReset();

    $display("[TB] reset and power-up clear");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset clr_busy", 32'(clr_busy), 32'd1);
    checkOutput("reset addr", 32'(addr), 32'd256);
    checkOutput("reset control outputs",
                {26'd0, lkp_if.lkp_ready, lkp_if.res_valid, lkp_if.res_hit, dict_full, wea_pcram, wea_acram}, 32'd0);
    checkOutput("reset code/count", {7'd0, lkp_if.res_code, entry_cnt}, 32'd0);
    checkOutput("reset write data", {11'd0, string_data, char_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweepCheck("power-up sweep");
    dirty = 0;
    for (int i = 256; i < 4096; i++) if (prefix_mem[i] !== EMPTY) dirty++;
    checkOutput("table cleared", 32'(dirty), 32'd0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      ew = !vecs[i].hit && vecs[i].code != EMPTY;
      runLookup($sformatf("vec%0d", i), vecs[i].prefix, vecs[i].ch, vecs[i].ins,
                vecs[i].hit, vecs[i].code, vecs[i].lat, ew);
    end
    checkOutput("vector entry_cnt", 32'(entry_cnt), 32'd5);

    $display("[TB] clear request colliding with a lookup");
    @(negedge clk);
    clr_req = 1'b1;
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_prefix = 13'h041;
    lkp_if.lkp_char = 8'h42;
    lkp_if.lkp_ins = 1'b0;
    #1;
    checkOutput("ready masked by clr_req", 32'(lkp_if.lkp_ready), 32'd0);
    @(negedge clk);
    clr_req = 1'b0;
    lkp_if.lkp_valid = 1'b0;
    sweepCheck("clr_req sweep");
    modelReset();

    $display("[TB] randomized lookups");
    for (int i = 0; i < 150; i++) begin
      rp = 13'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) rp = rp | 13'h1000;
      rc = 8'($urandom_range(0, 3));
      ri = ($urandom_range(0, 3) != 0);
      modelLookup(rp, rc, ri, eh, ec, el, ew);
      runLookup($sformatf("rand%0d", i), rp, rc, ri, eh, ec, el, ew);
      checkOutput($sformatf("rand%0d entry_cnt", i), 32'(entry_cnt), 32'(m_cnt));
      checkOutput($sformatf("rand%0d dict_full", i), 32'(dict_full), (m_cnt == TB_MAX) ? 32'd1 : 32'd0);
    end

    $display("[TB] fill to capacity");
    for (int i = 0; i < 64 && m_cnt < TB_MAX; i++) begin
      rp = 13'h800 + 13'(i);
      rc = 8'(i);
      modelLookup(rp, rc, 1'b1, eh, ec, el, ew);
      runLookup($sformatf("fill%0d", i), rp, rc, 1'b1, eh, ec, el, ew);
    end
    checkOutput("full entry_cnt", 32'(entry_cnt), 32'(TB_MAX));
    modelLookup(13'h900, 8'h55, 1'b1, eh, ec, el, ew);
    runLookup("insert while full", 13'h900, 8'h55, 1'b1, 1'b0, 13'h1FFF, el, 1'b0);
    checkOutput("dict_full asserted", 32'(dict_full), 32'd1);

    $display("[TB] reset during a probe");
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_prefix = 13'h041;
    lkp_if.lkp_char = 8'h42;
    lkp_if.lkp_ins = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lkp_if.lkp_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid-probe reset addr", 32'(addr), 32'd256);
    checkOutput("mid-probe reset clr_busy", 32'(clr_busy), 32'd1);
    el = 0;
    repeat (4) begin
      @(negedge clk);
      if (lkp_if.res_valid) el++;
    end
    checkOutput("no result under reset", 32'(el), 32'd0);
    rst = 1'b0;
    sweepCheck("restart sweep");
    modelReset();
    runLookup("post-restart insert", 13'h041, 8'h42, 1'b1, 1'b0, 13'h461, 4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
